// File: rtl/decode_register_file_if.sv
// Bundle between writeback/decode and the register file: write port, two read ports,
// issue/cancel scoreboard controls and the stall/error flags returned to the pipeline.
interface decode_register_file_if #(
    parameter int XLEN = 32
);
    logic            RegWriteW;
    logic [4:0]      RDW;
    logic [XLEN-1:0] ResultW;
    logic [4:0]      A1;
    logic [4:0]      A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic            IssueD;
    logic [4:0]      IssueRdD;
    logic            CancelE;
    logic [4:0]      CancelRdE;
    logic            StallD;
    logic            ErrorW;

    modport master (
        output RegWriteW, RDW, ResultW, A1, A2, IssueD, IssueRdD, CancelE, CancelRdE,
        input  RD1, RD2, StallD, ErrorW
    );

    modport slave (
        input  RegWriteW, RDW, ResultW, A1, A2, IssueD, IssueRdD, CancelE, CancelRdE,
        output RD1, RD2, StallD, ErrorW
    );
endinterface

// File: rtl/decode_register_file.sv
// 32 x XLEN register file with write-through bypass and, when SCOREBOARD_EN is defined,
// per-register pending-write counters driving StallD and a sticky underflow ErrorW.
module decode_register_file #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    decode_register_file_if.slave        bus
);

    logic [XLEN-1:0] regs [32];
    logic            wb_en;

    assign wb_en = bus.RegWriteW && (bus.RDW != 5'd0);

    // x0 is never written, so regs[0] stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[bus.RDW] <= bus.ResultW;
        end
    end

    always_comb begin
        bus.RD1 = '0;
        bus.RD2 = '0;
        if (bus.A1 != 5'd0) begin
            bus.RD1 = (wb_en && bus.RDW == bus.A1) ? bus.ResultW : regs[bus.A1];
        end
        if (bus.A2 != 5'd0) begin
            bus.RD2 = (wb_en && bus.RDW == bus.A2) ? bus.ResultW : regs[bus.A2];
        end
    end

`ifdef SCOREBOARD_EN
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_all [32];
    logic [31:0]       underflow;
    logic              stall;
    logic              a1_busy;
    logic              a2_busy;
    logic              issue_full;
    logic              error_reg;

    assign cnt_all[0]   = '0;
    assign underflow[0] = 1'b0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
        logic [PEND_W-1:0] cnt_reg;
        logic [PEND_W-1:0] cnt_next;
        logic              inc;
        logic              wb_dec;
        logic              cancel_dec;
        logic [PEND_W:0]   up;
        logic [PEND_W:0]   down;

        assign inc        = bus.IssueD && (bus.IssueRdD == 5'(gi)) && !stall;
        assign wb_dec     = bus.RegWriteW && (bus.RDW == 5'(gi));
        assign cancel_dec = bus.CancelE && (bus.CancelRdE == 5'(gi));

        // Saturate at zero; more retirements than pending writes is an error.
        always_comb begin
            up       = {1'b0, cnt_reg} + (PEND_W+1)'(inc);
            down     = (PEND_W+1)'(wb_dec) + (PEND_W+1)'(cancel_dec);
            cnt_next = (up >= down) ? PEND_W'(up - down) : '0;
        end

        assign underflow[gi] = down > {1'b0, cnt_reg};
        assign cnt_all[gi]   = cnt_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    // A source whose last pending write lands this cycle is covered by the bypass.
    always_comb begin
        a1_busy = (bus.A1 != 5'd0) && (cnt_all[bus.A1] != '0) &&
                  !((cnt_all[bus.A1] == PEND_W'(1)) && bus.RegWriteW && (bus.RDW == bus.A1));
        a2_busy = (bus.A2 != 5'd0) && (cnt_all[bus.A2] != '0) &&
                  !((cnt_all[bus.A2] == PEND_W'(1)) && bus.RegWriteW && (bus.RDW == bus.A2));
        issue_full = bus.IssueD && (bus.IssueRdD != 5'd0) &&
                     (cnt_all[bus.IssueRdD] == CNT_MAX) &&
                     !(bus.RegWriteW && (bus.RDW == bus.IssueRdD)) &&
                     !(bus.CancelE && (bus.CancelRdE == bus.IssueRdD));
        stall = a1_busy || a2_busy || issue_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else if (|underflow) begin
            error_reg <= 1'b1;
        end
    end

    assign bus.StallD = stall;
    assign bus.ErrorW = error_reg;
`else
    logic              unused_sb;
    logic [PEND_W-1:0] unused_pend;

    assign unused_sb   = ^{bus.IssueD, bus.IssueRdD, bus.CancelE, bus.CancelRdE};
    assign unused_pend = '0;
    assign bus.StallD  = 1'b0;
    assign bus.ErrorW  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_register_file.sv
// Directed bench for decode_register_file; scoreboard expectations collapse to zero
// when SCOREBOARD_EN is undefined.
module tb_decode_register_file;

`ifdef SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_register_file_if #(.XLEN(32)) bus ();

    decode_register_file #(.XLEN(32), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.RegWriteW = 1'b0; bus.RDW = '0; bus.ResultW = '0;
        bus.A1 = '0; bus.A2 = '0;
        bus.IssueD = 1'b0; bus.IssueRdD = '0;
        bus.CancelE = 1'b0; bus.CancelRdE = '0;
    endtask

    function automatic logic [31:0] sb(input logic v);
        return {31'd0, SB & v};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset read-back
        bus.A1 = 5'd5; bus.A2 = 5'd31; #1;
        check("rst_rd1", bus.RD1, 32'h0);
        check("rst_rd2", bus.RD2, 32'h0);
        check("rst_stall", {31'd0, bus.StallD}, 32'h0);
        check("rst_err", {31'd0, bus.ErrorW}, 32'h0);

        // Write with bypass (issue first so the writeback is legitimate)
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd3;
        tick();
        idle(); bus.RegWriteW = 1'b1; bus.RDW = 5'd3; bus.ResultW = 32'h0000000A; bus.A1 = 5'd3; #1;
        check("byp_rd1", bus.RD1, 32'h0000000A);
        check("byp_stall", {31'd0, bus.StallD}, 32'h0);
        tick();
        bus.RegWriteW = 1'b0; #1;
        check("hold_rd1", bus.RD1, 32'h0000000A);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd0; bus.ResultW = 32'hFFFFFFFF; bus.A1 = 5'd0; #1;
        check("x0_byp", bus.RD1, 32'h0);
        tick();
        bus.RegWriteW = 1'b0; bus.A2 = 5'd0; #1;
        check("x0_rd", bus.RD1, 32'h0);
        check("x0_err", {31'd0, bus.ErrorW}, 32'h0);

        // Hazard stall and bypass release
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd7; #1;
        check("iss7_stall", {31'd0, bus.StallD}, 32'h0);
        tick();
        idle(); bus.A1 = 5'd7; #1;
        check("haz7_stall", {31'd0, bus.StallD}, sb(1'b1));
        tick();
        bus.RegWriteW = 1'b1; bus.RDW = 5'd7; bus.ResultW = 32'h5; #1;
        check("wb7_stall", {31'd0, bus.StallD}, 32'h0);
        check("wb7_rd1", bus.RD1, 32'h5);
        tick();
        bus.RegWriteW = 1'b0; #1;
        check("post7_rd1", bus.RD1, 32'h5);

        // Counter full on r9
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("iss9_%0d", i), {31'd0, bus.StallD}, 32'h0);
            tick();
        end
        check("full9_stall", {31'd0, bus.StallD}, sb(1'b1));
        tick();
        idle(); bus.A1 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            bus.RegWriteW = 1'b1; bus.RDW = 5'd9; bus.ResultW = 32'h90 + 32'(i); #1;
            check($sformatf("wb9_stall_%0d", i), {31'd0, bus.StallD}, sb(i < 2));
            check($sformatf("wb9_rd1_%0d", i), bus.RD1, 32'h90 + 32'(i));
            tick();
        end
        bus.RegWriteW = 1'b0; #1;
        check("drain9_stall", {31'd0, bus.StallD}, 32'h0);
        check("drain9_err", {31'd0, bus.ErrorW}, 32'h0);

        // Cancel then underflow
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd4;
        tick();
        idle(); bus.A1 = 5'd4; #1;
        check("pend4_stall", {31'd0, bus.StallD}, sb(1'b1));
        bus.CancelE = 1'b1; bus.CancelRdE = 5'd4;
        tick();
        bus.CancelE = 1'b0; #1;
        check("cancel4_stall", {31'd0, bus.StallD}, 32'h0);
        check("cancel4_err", {31'd0, bus.ErrorW}, 32'h0);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd4; bus.ResultW = 32'h44; #1;
        check("uf4_rd1", bus.RD1, 32'h44);
        tick();
        bus.RegWriteW = 1'b0; #1;
        check("uf4_err", {31'd0, bus.ErrorW}, sb(1'b1));
        tick();
        tick();
        check("uf4_sticky", {31'd0, bus.ErrorW}, sb(1'b1));

        // Simultaneous issue and retire on r6
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd6;
        tick();
        bus.RegWriteW = 1'b1; bus.RDW = 5'd6; bus.ResultW = 32'h66; #1;
        check("sim6_stall", {31'd0, bus.StallD}, 32'h0);
        tick();
        idle(); bus.A1 = 5'd6; #1;
        check("sim6_pend", {31'd0, bus.StallD}, sb(1'b1));
        check("sim6_rd1", bus.RD1, 32'h66);
        idle(); bus.IssueD = 1'b1; bus.IssueRdD = 5'd6;
        tick();

        // Reset with r6 pending twice
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0; bus.A1 = 5'd6; #1;
        check("rst6_stall", {31'd0, bus.StallD}, 32'h0);
        check("rst6_err", {31'd0, bus.ErrorW}, 32'h0);
        check("rst6_rd1", bus.RD1, 32'h0);
        bus.RegWriteW = 1'b1; bus.RDW = 5'd6; bus.ResultW = 32'h77;
        tick();
        bus.RegWriteW = 1'b0; #1;
        check("stale6_err", {31'd0, bus.ErrorW}, sb(1'b1));
        check("stale6_rd1", bus.RD1, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_register_file.md
Name: decode_register_file

Overview:
- Consumer end of the writeback interface: takes RegWriteW/RDW/ResultW from writeback_cycle and commits them into a 32 x 32-bit integer register file.
- Serves the two decode-stage read ports.
- Includes a per-register pending-write scoreboard. It flags decode read-after-write hazards against writes still in flight between issue and writeback.
- Sits between writeback_cycle (write side) and decode_cycle (read side) in the 5-stage pipeline.

Parameters:
- XLEN, 32, data width of each register
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W - 1

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- RegWriteW  input  1  writeback write enable
- RDW  input  5  writeback destination register
- ResultW  input  XLEN  writeback data
- A1  input  5  decode source register 1 address
- A2  input  5  decode source register 2 address
- RD1  output  XLEN  read data for A1
- RD2  output  XLEN  read data for A2
- IssueD  input  1  decode issues an instruction that will write IssueRdD
- IssueRdD  input  5  destination of the issued instruction
- CancelE  input  1  in-flight writer squashed (flush); its write will never arrive
- CancelRdE  input  5  destination of the squashed writer
- StallD  output  1  decode must hold: source is pending, or issue target counter is full
- ErrorW  output  1  sticky: writeback or cancel arrived for a register with pending count 0

Behaviour:
- Reset (rst=1 at rising edge):
  - All 31 registers <= 0; all pending counters <= 0; ErrorW <= 0.
  - Any RegWriteW, IssueD or CancelE in the reset cycle is dropped.
- x0:
  - Reads return 0.
  - Writes are ignored.
  - Never pending; IssueD, CancelE and RegWriteW with address 0 do not touch counters or ErrorW.
- Write:
  - RegWriteW=1 and RDW!=0 -> reg[RDW] <= ResultW at the rising edge.
  - Counter[RDW] decrements in the same edge.
- Read (combinational, zero latency):
  - RDn = reg[An].
  - Write-through bypass: if RegWriteW && RDW==An && An!=0 then RDn = ResultW in the same cycle.
- Counter update per register r, per edge:
  - inc = IssueD && IssueRdD==r && !StallD
  - dec = (RegWriteW && RDW==r) + (CancelE && CancelRdE==r); dec can be 0, 1 or 2
  - next = cnt + inc - dec
- Counter boundaries:
  - Underflow: if dec > cnt, clamp to 0 and set ErrorW=1 (sticky until rst).
  - Overflow: an issue is never accepted when cnt == max, because StallD is forced.
- Simultaneous events: issue and retire of the same register in one edge leave the count unchanged.
- StallD (combinational) = any of:
  - A1!=0 && eff_cnt[A1]!=0
  - A2!=0 && eff_cnt[A2]!=0
  - IssueD && IssueRdD!=0 && cnt[IssueRdD]==max && no dec on IssueRdD this cycle
- eff_cnt[r] = cnt[r] minus the writeback decrement this cycle. A source whose last pending write lands this cycle is served by the bypass and does not stall.
- While StallD=1, the issue is not counted. Decode re-presents the same IssueD/IssueRdD next cycle.
- Reset mid-operation: all pending state is discarded. The pipeline flush accompanying rst guarantees no stale writebacks follow. A stale writeback after reset sets ErrorW.

Optional Feature:
- Macro: SCOREBOARD_EN
- Defined: pending counters, StallD and ErrorW are implemented as specified above.
- Undefined:
  - No counters are synthesised.
  - StallD tied 0, ErrorW tied 0.
  - IssueD/CancelE and their address ports are ignored.
  - Register file, bypass and x0 rules are unchanged.

Test Plan:
1. Reset then read-back: rst=1 two cycles, release; A1=5, A2=31 -> RD1=0, RD2=0, StallD=0, ErrorW=0.
2. Write/bypass:
   - Cycle N: RegWriteW=1, RDW=3, ResultW=0x0000000A, A1=3 -> RD1=0x0000000A in cycle N.
   - Cycle N+1: RegWriteW=0 -> RD1 still 0x0000000A.
   - RDW=0, ResultW=0xFFFFFFFF -> reading A1=0 returns 0.
3. Hazard stall:
   - IssueD=1, IssueRdD=7; next cycle A1=7 -> StallD=1.
   - Writeback RDW=7, ResultW=0x5 -> StallD=0 that cycle, RD1=0x5.
4. Counter full: issue rd=9 three times with no writeback; fourth IssueD rd=9 (A1=A2=0) -> StallD=1, count stays 3. Three writebacks to 9 -> count 0, ErrorW=0.
5. Cancel and underflow:
   - Issue rd=4, then CancelE rd=4 -> A1=4 no stall.
   - Further RegWriteW RDW=4 -> ErrorW=1, stays 1 until rst.
6. Simultaneous:
   - Same edge IssueD rd=6 and RegWriteW RDW=6 with prior count 1 -> count stays 1; A1=6 stalls next cycle.
   - rst with pending count 2 -> all counts 0, StallD=0.
